// File: rtl/pwm_ctrl_pkg.sv
// Shared types and defaults for the PWM duty-path controllers.
// Optional build macro used by the ramp controller: PWM_RAMP_DWELL_EN.
package pwm_ctrl_pkg;

    localparam int DEF_WIDTH   = 8;
    localparam int DEF_DWELL_W = 4;

    // Last phase value of a period at the default width (2^WIDTH - 1).
    localparam logic [DEF_WIDTH-1:0] PERIOD_MAX = {DEF_WIDTH{1'b1}};

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } state_e;

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command channel of the ramp controller: valid/ready handshake carrying
// target duty, step size and (with PWM_RAMP_DWELL_EN) a dwell count.
interface pwm_ramp_ctrl_if
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
`ifdef PWM_RAMP_DWELL_EN
    ,
    parameter int DWELL_W = DEF_DWELL_W
`endif
) ();

    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_target;
    logic [WIDTH-1:0] cmd_step;
`ifdef PWM_RAMP_DWELL_EN
    logic [DWELL_W-1:0] cmd_dwell;
`endif

`ifdef PWM_RAMP_DWELL_EN
    modport master (output cmd_valid, cmd_target, cmd_step, cmd_dwell, input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_target, cmd_step, cmd_dwell, output cmd_ready);
`else
    modport master (output cmd_valid, cmd_target, cmd_step, input  cmd_ready);
    modport slave  (input  cmd_valid, cmd_target, cmd_step, output cmd_ready);
`endif

endinterface

// File: rtl/pwm_phase_counter.sv
// Free-running WIDTH-bit PWM phase counter. Wraps from all-ones to zero and
// never stalls; period_end flags the last phase of each period.
module pwm_phase_counter
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] phase_o,
    output logic             period_end_o
);

    logic [WIDTH-1:0] phase_q;
    logic [WIDTH-1:0] phase_d;

    assign phase_d = phase_q + WIDTH'(1);

    // Phase register: synchronous clear, otherwise count up with natural wrap.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of process evaluation order.
        if (rst) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

    assign phase_o      = phase_q;
    assign period_end_o = &phase_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// PWM duty ramp sequencer. Accepts target/step commands and moves the duty
// output toward the target by one step per PWM period, changing duty only on
// the edge that ends a period so the comparator (phase < duty) never sees a
// mid-period change. Optional build macro: PWM_RAMP_DWELL_EN adds a cmd_dwell
// field giving D extra periods between steps.
module pwm_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int DWELL_W = DEF_DWELL_W
) (
    input  logic             clk,
    input  logic             rst,
    pwm_ramp_ctrl_if.slave   cmd,
    input  logic             abort_i,
    output logic [WIDTH-1:0] duty_o,
    output logic [WIDTH-1:0] phase_o,
    output logic             period_end_o,
    output logic             busy_o,
    output logic             done_o
);

    if (WIDTH < 2 || DWELL_W < 1) begin : g_bad_cfg
        $error("pwm_ramp_ctrl: WIDTH must be >= 2 and DWELL_W >= 1");
    end

    state_e           state_q, state_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [WIDTH-1:0] target_q, target_d;
    logic [WIDTH-1:0] step_q, step_d;
    logic             done_q, done_d;
    logic             init_q;
    logic             period_end;
    logic             cmd_ready;
    logic             step_due;
    logic             ramp_up;
    logic             reach;
    logic [WIDTH:0]   sum_up;
    logic [WIDTH:0]   sum_dn;
`ifdef PWM_RAMP_DWELL_EN
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
`endif

    pwm_phase_counter #(.WIDTH(WIDTH)) u_phase (
        .clk          (clk),
        .rst          (rst),
        .phase_o      (phase_o),
        .period_end_o (period_end)
    );

    // init_q holds cmd_ready low while reset is applied and for the
    // remainder of that cycle, without any path from rst to the output.
    assign cmd_ready     = init_q && (state_q == IDLE);
    assign cmd.cmd_ready = cmd_ready;

`ifdef PWM_RAMP_DWELL_EN
    assign step_due = (dwell_cnt_q == dwell_q);
`else
    assign step_due = 1'b1;
`endif

    // Distance checks at WIDTH+1 bits: "diff <= step" is rewritten as a
    // carry-safe sum comparison, so neither direction can wrap.
    assign ramp_up = (target_q > duty_q);
    assign sum_up  = {1'b0, duty_q}   + {1'b0, step_q};
    assign sum_dn  = {1'b0, target_q} + {1'b0, step_q};
    assign reach   = ramp_up ? (sum_up >= {1'b0, target_q})
                             : (sum_dn >= {1'b0, duty_q});

    // Next-state and datapath decode for the IDLE/RAMP sequencer.
    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        duty_d   = duty_q;
        target_d = target_q;
        step_d   = step_q;
        done_d   = 1'b0;
`ifdef PWM_RAMP_DWELL_EN
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
`endif
        case (state_q)
            IDLE: begin
                // abort is deliberately ignored here.
                if (cmd.cmd_valid && cmd_ready) begin
                    target_d = cmd.cmd_target;
                    step_d   = cmd.cmd_step;
                    state_d  = RAMP;
`ifdef PWM_RAMP_DWELL_EN
                    dwell_d     = cmd.cmd_dwell;
                    dwell_cnt_d = '0;
`endif
                end
            end
            RAMP: begin
                if (abort_i) begin
                    // Abort beats a coincident boundary: duty is held.
                    state_d = IDLE;
`ifdef PWM_RAMP_DWELL_EN
                    dwell_cnt_d = '0;
`endif
                end else if (period_end && step_due) begin
`ifdef PWM_RAMP_DWELL_EN
                    dwell_cnt_d = '0;
`endif
                    if (step_q == '0 || reach) begin
                        duty_d  = target_q;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (ramp_up) begin
                        duty_d = duty_q + step_q;
                    end else begin
                        duty_d = duty_q - step_q;
                    end
                end
`ifdef PWM_RAMP_DWELL_EN
                else if (period_end) begin
                    dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and duty register; reset discards any ramp in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            done_q  <= 1'b0;
            init_q  <= 1'b0;
`ifdef PWM_RAMP_DWELL_EN
            dwell_cnt_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
            init_q  <= 1'b1;
`ifdef PWM_RAMP_DWELL_EN
            dwell_cnt_q <= dwell_cnt_d;
`endif
        end
    end

    // Latched command fields, loaded on every accept.
    always_ff @(posedge clk) begin
        // NOTE: no reset here -- these are only read in RAMP, which is
        // entered solely through an accept that loads them.
        target_q <= target_d;
        step_q   <= step_d;
`ifdef PWM_RAMP_DWELL_EN
        dwell_q  <= dwell_d;
`endif
    end

    assign duty_o       = duty_q;
    assign period_end_o = period_end;
    assign busy_o       = (state_q == RAMP);
    assign done_o       = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: a trajectory-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_pwm_ramp_ctrl;
    import pwm_ctrl_pkg::*;

    localparam int PERIOD = int'(PERIOD_MAX) + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       abort = 1'b0;
    logic [7:0] duty_o;
    logic [7:0] phase_o;
    logic       period_end_o;
    logic       busy_o;
    logic       done_o;

`ifdef PWM_RAMP_DWELL_EN
    pwm_ramp_ctrl_if #(.WIDTH(8), .DWELL_W(4)) cmd_if ();
    int dwell_req = 0;
`else
    pwm_ramp_ctrl_if #(.WIDTH(8)) cmd_if ();
`endif

    pwm_ramp_ctrl #(.WIDTH(8), .DWELL_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd          (cmd_if),
        .abort_i      (abort),
        .duty_o       (duty_o),
        .phase_o      (phase_o),
        .period_end_o (period_end_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // At accept, the whole duty trajectory is planned as a list of values;
    // one value is consumed every (D+1) period boundaries.
    int         m_cyc = 0;
    logic [7:0] m_duty = 8'h00;
    logic       m_ramping = 1'b0;
    logic       m_done = 1'b0;
    logic       m_init = 1'b0;
    int         m_nb = 0;
    int         m_dwell = 0;
    logic [7:0] m_vals[$];

    function automatic void plan(input int start, input int tgt, input int stp);
        int v = start;
        m_vals.delete();
        if (stp == 0 || v == tgt) begin
            m_vals.push_back(8'(tgt));
        end else begin
            while (v != tgt) begin
                if (tgt > v) v = (tgt - v <= stp) ? tgt : v + stp;
                else         v = (v - tgt <= stp) ? tgt : v - stp;
                m_vals.push_back(8'(v));
            end
        end
    endfunction

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_cyc = 0; m_duty = 8'h00; m_ramping = 1'b0; m_done = 1'b0;
            m_init = 1'b0; m_nb = 0; m_vals.delete();
        end else begin
            m_done = 1'b0;
            if (m_ramping) begin
                if (abort) begin
                    m_ramping = 1'b0;
                    m_vals.delete();
                end else if ((m_cyc % PERIOD) == PERIOD - 1) begin
                    m_nb++;
                    if (m_nb % (m_dwell + 1) == 0) begin
                        m_duty = m_vals.pop_front();
                        if (m_vals.size() == 0) begin
                            m_done = 1'b1;
                            m_ramping = 1'b0;
                        end
                    end
                end
            end else if (m_init && cmd_if.cmd_valid) begin
                plan(int'(m_duty), int'(cmd_if.cmd_target), int'(cmd_if.cmd_step));
`ifdef PWM_RAMP_DWELL_EN
                m_dwell = int'(cmd_if.cmd_dwell);
`else
                m_dwell = 0;
`endif
                m_ramping = 1'b1;
                m_nb = 0;
            end
            m_init = 1'b1;
            m_cyc++;
        end
    end

    // ---------------- every-cycle compare ----------------
    logic cmp_en = 1'b0;

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            check("duty",       duty_o,           m_duty);
            check("phase",      phase_o,          32'(m_cyc % PERIOD));
            check("period_end", period_end_o,     (m_cyc % PERIOD) == PERIOD - 1);
            check("busy",       busy_o,           m_ramping);
            check("done",       done_o,           m_done);
            check("cmd_ready",  cmd_if.cmd_ready, m_init && !m_ramping);
        end
    end

    // ---------------- duty change monitor ----------------
    typedef struct {
        logic [7:0] val;
        int         cyc;
    } chg_t;

    chg_t       seen[$];
    int         tb_cyc = 0;
    logic [7:0] prev_duty = 8'h00;

    initial forever begin
        @(posedge clk);
        tb_cyc++;
        #1;
        if (rst) begin
            prev_duty = 8'h00;
        end else if (duty_o !== prev_duty) begin
            seen.push_back('{val: duty_o, cyc: tb_cyc});
            prev_duty = duty_o;
        end
    end

    // ---------------- helpers (all start and end at a negedge) ----------------
    task automatic send(input logic [7:0] tgt, input logic [7:0] stp);
        int n = 0;
        while (!cmd_if.cmd_ready && n < 4 * PERIOD) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", cmd_if.cmd_ready, 1'b1);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_target = tgt;
        cmd_if.cmd_step   = stp;
`ifdef PWM_RAMP_DWELL_EN
        cmd_if.cmd_dwell  = 4'(dwell_req);
`endif
        @(posedge clk);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (done_o) break;
        end
        check("done_seen", done_o, 1'b1);
    endtask

    task automatic wait_duty(input logic [7:0] val, input int budget);
        int n = 0;
        while (duty_o !== val && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_duty", duty_o, val);
    endtask

    task automatic wait_phase_max(input int budget);
        int n = 0;
        while (phase_o !== PERIOD_MAX && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_phase_max", phase_o, PERIOD_MAX);
    endtask

    task automatic check_seen(input string tag, input logic [7:0] exp_q[$], input int gap);
        check({tag, "_count"}, seen.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++) begin
            check($sformatf("%s_val%0d", tag, i), seen[i].val, exp_q[i]);
            if (i > 0) check($sformatf("%s_gap%0d", tag, i), seen[i].cyc - seen[i-1].cyc, gap);
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int         n;
        logic [7:0] exp_q[$];

        cmd_if.cmd_valid  = 1'b0;
        cmd_if.cmd_target = 8'h00;
        cmd_if.cmd_step   = 8'h00;
`ifdef PWM_RAMP_DWELL_EN
        cmd_if.cmd_dwell  = 4'h0;
`endif
        @(posedge clk);
        cmp_en = 1'b1;
        @(negedge clk);
        check("rst_ready",      cmd_if.cmd_ready, 1'b0);
        check("rst_duty",       duty_o,           8'h00);
        check("rst_phase",      phase_o,          8'h00);
        check("rst_busy",       busy_o,           1'b0);
        check("rst_done",       done_o,           1'b0);
        check("rst_period_end", period_end_o,     1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", cmd_if.cmd_ready, 1'b1);

        // Ramp up 0 -> 0x40 in 0x10 steps, one per period.
        seen.delete();
        send(8'h40, 8'h10);
        wait_done(6 * PERIOD, n);
        check("up_done_duty",  duty_o,           8'h40);
        check("up_done_ready", cmd_if.cmd_ready, 1'b1);
        check("up_done_busy",  busy_o,           1'b0);
        check("up_done_phase", phase_o,          8'h00);
        exp_q = '{8'h10, 8'h20, 8'h30, 8'h40};
        check_seen("up", exp_q, PERIOD);

        // Jump with step 0, issued back-to-back in the done cycle.
        seen.delete();
        send(8'hC8, 8'h00);
        wait_done(2 * PERIOD, n);
        exp_q = '{8'hC8};
        check_seen("jump", exp_q, 0);

        // Ramp down with final-step clamp.
        send(8'h40, 8'h00);
        wait_done(2 * PERIOD, n);
        seen.delete();
        send(8'h05, 8'h10);
        wait_done(6 * PERIOD, n);
        exp_q = '{8'h30, 8'h20, 8'h10, 8'h05};
        check_seen("down", exp_q, PERIOD);

        // Top clamp: 0xF0 + 0x20 must land on 0xFF, not wrap.
        send(8'hF0, 8'h00);
        wait_done(2 * PERIOD, n);
        seen.delete();
        send(8'hFF, 8'h20);
        wait_done(2 * PERIOD, n);
        exp_q = '{8'hFF};
        check_seen("top", exp_q, 0);

        // Target equal to current duty still completes at the first boundary.
        seen.delete();
        send(8'hFF, 8'h05);
        wait_done(2 * PERIOD, n);
        check("eq_changes", seen.size(), 0);
        check("eq_duty",    duty_o,      8'hFF);

        // Accept on a boundary edge: that edge does not count.
        wait_phase_max(2 * PERIOD);
        send(8'h50, 8'h00);
        wait_done(3 * PERIOD, n);
        check("bnd_latency", n,      PERIOD);
        check("bnd_duty",    duty_o, 8'h50);

        // Abort coincident with a boundary edge mid-ramp.
        send(8'h00, 8'h00);
        wait_done(2 * PERIOD, n);
        send(8'h80, 8'h10);
        wait_duty(8'h20, 4 * PERIOD);
        wait_phase_max(2 * PERIOD);
        abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        check("abort_duty",  duty_o,           8'h20);
        check("abort_busy",  busy_o,           1'b0);
        check("abort_ready", cmd_if.cmd_ready, 1'b1);
        check("abort_done",  done_o,           1'b0);
        repeat (PERIOD + 10) @(negedge clk);
        check("abort_hold",  duty_o,           8'h20);

        // Abort in IDLE is ignored; a same-cycle command is accepted.
        abort = 1'b1;
        send(8'h10, 8'h00);
        abort = 1'b0;
        check("idle_abort_busy", busy_o, 1'b1);
        wait_done(2 * PERIOD, n);
        check("idle_abort_duty", duty_o, 8'h10);

        // Reset mid-ramp.
        send(8'h80, 8'h10);
        wait_duty(8'h30, 4 * PERIOD);
        repeat (37) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_duty",  duty_o,           8'h00);
        check("midrst_phase", phase_o,          8'h00);
        check("midrst_ready", cmd_if.cmd_ready, 1'b0);
        check("midrst_busy",  busy_o,           1'b0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", cmd_if.cmd_ready, 1'b1);

`ifdef PWM_RAMP_DWELL_EN
        // Dwell 2: one step every three periods, done within nine periods.
        dwell_req = 0;
        send(8'h00, 8'h00);
        wait_done(2 * PERIOD, n);
        seen.delete();
        dwell_req = 2;
        send(8'h30, 8'h10);
        wait_done(10 * PERIOD, n);
        exp_q = '{8'h10, 8'h20, 8'h30};
        check_seen("dwell", exp_q, 3 * PERIOD);
        check("dwell_periods", (n + PERIOD - 1) / PERIOD, 9);
        dwell_req = 0;
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Sequencer for an 8-bit PWM duty path. Accepts a target duty and step size over a valid/ready command interface. Ramps its `duty` output toward the target by one step per PWM period, updating only at period boundaries so the comparator never sees a mid-period duty change. Owns the free-running phase counter, so `duty` and `phase` are always aligned; the downstream comparator forms `phase < duty`.

## Interface
- `WIDTH`, 8: duty and phase width; period = 2^WIDTH cycles
- `DWELL_W`, 4: dwell-count width, used only when the dwell feature is compiled in
- `clk`  in  1  clock; all state changes on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  high when the block can accept a command
- `cmd_target`  in  WIDTH  final duty
- `cmd_step`  in  WIDTH  per-period increment magnitude; 0 = jump to target
- `cmd_dwell`  in  DWELL_W  extra periods per step; port present only with `PWM_RAMP_DWELL_EN`
- `abort`  in  1  stop the ramp, hold the current duty
- `duty`  out  WIDTH  registered duty value
- `phase`  out  WIDTH  registered phase counter
- `period_end`  out  1  high while `phase` == 2^WIDTH-1
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse when the ramp reaches its target

## Operation
- Phase counter:
  - free-running 0 → 2^WIDTH-1, then wraps to 0; never stalls
  - `period_end` = (`phase` == all-ones), combinational from the `phase` register
- Boundary edge: the clock edge at which `period_end` is high. All `duty` updates happen only on this edge, so a new `duty` first appears with `phase` = 0.
- FSM states:
  - IDLE: `cmd_ready`=1. A handshake (`cmd_valid` & `cmd_ready`) latches target, step and dwell, then moves to RAMP.
  - RAMP: `cmd_ready`=0. At each qualifying boundary edge, let diff = |target − duty|:
    - if step==0 or diff ≤ step: `duty` ← target, `done` pulses, state → IDLE
    - else `duty` ← `duty` ± step, toward target
- Arithmetic:
  - diff and sum are computed at WIDTH+1 bits
  - `duty` never wraps and never overshoots; the final step is clamped to target
- Target equal to current duty: the command is still accepted. The first boundary completes it (`duty` unchanged, `done` pulses).
- `abort`:
  - in RAMP: state → IDLE next edge, `duty` held, no `done`
  - in IDLE: ignored; a command offered in the same cycle is accepted
  - `abort` coincident with a boundary edge in RAMP: abort wins, no `duty` update
- Reset:
  - `duty`=0, `phase`=0, state IDLE, `done`=0, `busy`=0; `period_end`=0 as a consequence
  - `cmd_ready`=0 while `rst` is high, 1 on the first cycle after
  - reset mid-ramp discards the command; `duty` returns to 0 immediately

## Timing
- Command accepted at edge t → `busy`=1 from t+1.
- First duty change occurs at the first boundary edge after t. If acceptance coincides with a boundary edge, that edge does not count.
- Steps to completion: ceil(diff/step) periods, or 1 period if step==0.
- `done` is high in the same cycle `duty` first shows the final value. `busy`=0 and `cmd_ready`=1 are asserted in that same cycle.
- Back-to-back commands: the next command can be accepted in the `done` cycle.
- `duty`, `phase`, `done` and `busy` are registered outputs. `cmd_ready` and `period_end` are decoded from registers only, with no combinational input-to-output paths.

## Configuration
- `PWM_RAMP_DWELL_EN` defined:
  - `cmd_dwell` port exists; D is latched at the handshake
  - a dwell counter counts boundary edges in RAMP; a step applies only on the boundary where the count equals D, after which the counter clears
  - result: one step every D+1 periods; the counter clears on accept, abort and reset
- Undefined: no `cmd_dwell` port and no dwell counter; one step every period, equivalent to D=0.

## Structure
- Shared package `pwm_ctrl_pkg`:
  - state enum (IDLE, RAMP)
  - default WIDTH and DWELL_W constants
  - PERIOD_MAX = 2^WIDTH-1
- Sub-module `pwm_phase_counter`:
  - WIDTH-bit wrap counter with synchronous reset
  - outputs `phase` and `period_end`
  - reused by future multi-channel controllers

## Test plan
- Ramp up: reset, then cmd target=0x40 step=0x10 → `duty` 0x10, 0x20, 0x30, 0x40 at four consecutive boundaries (256 cycles apart); `done` with 0x40; `cmd_ready`=1 in that cycle.
- Jump: cmd target=0xC8 step=0 → `duty`=0xC8 at the first boundary, single `done`, no intermediate values.
- Ramp down with clamp: from 0x40, target=0x05 step=0x10 → 0x30, 0x20, 0x10, 0x05; never below 0x05, no underflow.
- Top clamp: from 0xF0, target=0xFF step=0x20 → single step to 0xFF, no wrap to 0x10.
- Abort on a boundary edge mid-ramp (`duty`=0x20 heading to 0x80) → `duty` stays 0x20, no `done`, `busy`=0 and `cmd_ready`=1 next cycle. Then reset mid-ramp → `duty`=0, `phase`=0.
- With `PWM_RAMP_DWELL_EN`: dwell=2, target=0x30 step=0x10 from 0 → `duty` changes every 3 periods (768 cycles); `done` after 9 periods.
